// File: rtl/fifo_bank_pkg.sv
// Shared types and constants for the IF/OF FIFO bank sequencer.
package fifo_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit positions inside the 2-bit ctrl / resp buses of the buffer bank
    localparam int WR    = 0;
    localparam int RD    = 1;
    localparam int FULL  = 0;
    localparam int EMPTY = 1;

    localparam int PERF_CNT_W = 16;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_bank_credit.sv
// Up/down credit counter bounding rows in flight between IF read and OF read.
module fifo_bank_credit #(
    parameter int DEPTH_WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic dec,
    input  logic inc,
    output logic has_credit
);

    localparam logic [DEPTH_WIDTH:0] CREDIT_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};

    logic [DEPTH_WIDTH:0] credit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            credit <= CREDIT_MAX;
        else if (dec && !inc)
            credit <= credit - 1'b1;
        else if (inc && !dec)
            credit <= credit + 1'b1;
    end

    assign has_credit = (credit != '0);

endmodule

// File: rtl/fifo_bank_ctrl.sv
// Sequences one tile through the IF bank, PE array and OF bank.
// Optional stall counters enabled by defining FIFO_BANK_CTRL_PERF_EN.
module fifo_bank_ctrl
    import fifo_bank_pkg::*;
#(
    parameter int DEPTH_WIDTH = 2,
    parameter int PE_LATENCY  = 3,
    parameter int ROW_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ROW_CNT_W-1:0]  num_rows_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic [1:0]            if_fifo_ctrl,
    input  logic [1:0]            if_fifo_resp,
    output logic [1:0]            of_fifo_ctrl,
    input  logic [1:0]            of_fifo_resp,
    output logic                  pe_valid_o,
    input  logic                  sink_ready_i,
    output logic                  sink_valid_o,
    output logic                  busy_o,
`ifdef FIFO_BANK_CTRL_PERF_EN
    output logic [PERF_CNT_W-1:0] stall_src_o,
    output logic [PERF_CNT_W-1:0] stall_sink_o,
`endif
    output logic                  done_o
);

    state_e               state;
    logic [ROW_CNT_W-1:0] num_rows, rows_in, rows_out, rows_done, rows_done_nxt;
    logic [PE_LATENCY:0]  vld_pipe;
    logic                 run, if_full, if_empty, of_full, of_empty;
    logic                 if_wr, if_rd, of_wr, of_rd, has_credit;

    assign run      = (state == RUN);
    assign if_full  = if_fifo_resp[FULL];
    assign if_empty = if_fifo_resp[EMPTY];
    assign of_full  = of_fifo_resp[FULL];
    assign of_empty = of_fifo_resp[EMPTY];

    assign src_ready_o = run && !if_full && (rows_in < num_rows);
    assign if_wr       = src_valid_i && src_ready_o;
    assign if_rd       = run && !if_empty && has_credit;
    assign of_wr       = vld_pipe[PE_LATENCY];
    assign of_rd       = run && !of_empty && sink_ready_i;
    assign pe_valid_o  = vld_pipe[0];

    always_comb begin
        if_fifo_ctrl     = '0;
        of_fifo_ctrl     = '0;
        if_fifo_ctrl[WR] = if_wr;
        if_fifo_ctrl[RD] = if_rd;
        of_fifo_ctrl[WR] = of_wr;
        of_fifo_ctrl[RD] = of_rd;
    end

    // Completion is judged on the beat itself so done follows the last beat by one cycle
    assign rows_done_nxt = rows_done + ROW_CNT_W'(sink_valid_o);

    fifo_bank_credit #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_credit (
        .clk        (clk),
        .rst        (rst),
        .dec        (if_rd),
        .inc        (of_rd),
        .has_credit (has_credit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            num_rows  <= '0;
            rows_in   <= '0;
            rows_out  <= '0;
            rows_done <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state     <= RUN;
                        busy_o    <= 1'b1;
                        num_rows  <= (num_rows_i == '0) ? ROW_CNT_W'(1) : num_rows_i;
                        rows_in   <= '0;
                        rows_out  <= '0;
                        rows_done <= '0;
                    end
                end
                RUN: begin
                    if (if_wr) rows_in  <= rows_in + ROW_CNT_W'(1);
                    if (if_rd) rows_out <= rows_out + ROW_CNT_W'(1);
                    rows_done <= rows_done_nxt;
                    if (rows_done_nxt == num_rows) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    // vld_pipe[0] is the IF read-data valid; the tail lines up with the PE result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe     <= '0;
            sink_valid_o <= 1'b0;
        end else begin
            vld_pipe     <= {vld_pipe[PE_LATENCY-1:0], if_rd};
            sink_valid_o <= of_rd;
        end
    end

`ifdef FIFO_BANK_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_src_o  <= '0;
            stall_sink_o <= '0;
        end else if (state == IDLE && start_i) begin
            stall_src_o  <= '0;
            stall_sink_o <= '0;
        end else if (run) begin
            if (src_valid_i && !src_ready_o) stall_src_o  <= sat_inc(stall_src_o);
            if (!of_empty && !sink_ready_i)  stall_sink_o <= sat_inc(stall_sink_o);
        end
    end
`endif

    a_of_wr_not_full: assert property (@(posedge clk) disable iff (!rst) !(of_wr && of_full));
    a_rows_out_bound: assert property (@(posedge clk) disable iff (!rst) rows_out <= num_rows);

endmodule

// File: doc/fifo_bank_ctrl.md
Name: fifo_bank_ctrl

Overview:
Sequences the IF/OF FIFO buffer bank for one tile of NUM_ROWS rows.
- Admits rows from the source into the IF bank.
- Issues IF reads to the PE array.
- Writes PE results into the OF bank after a fixed PE latency.
- Drains the OF bank to the sink.
Sits between the tile loader/PE array and the buffer bank, driving its 2-bit ctrl buses and consuming its 2-bit resp buses.

Parameters:
DEPTH_WIDTH, 2, log2 of FIFO depth; depth D = 2**DEPTH_WIDTH
PE_LATENCY, 3, cycles from pe_valid_o to PE result valid (>=1)
ROW_CNT_W, 8, width of row counters and num_rows_i

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start_i  in  1  start tile; sampled in IDLE only
num_rows_i  in  ROW_CNT_W  rows in tile; latched on start; 0 treated as 1
src_valid_i  in  1  source has a row on the IF bank write data
src_ready_o  out  1  controller accepts the row this cycle
if_fifo_ctrl  out  2  [0]=IF wr_en, [1]=IF rd_en
if_fifo_resp  in  2  [0]=IF full, [1]=IF empty
of_fifo_ctrl  out  2  [0]=OF wr_en, [1]=OF rd_en
of_fifo_resp  in  2  [0]=OF full, [1]=OF empty
pe_valid_o  out  1  IF read data valid at PE array inputs this cycle
sink_ready_i  in  1  sink can take an OF row
sink_valid_o  out  1  OF read data valid at sink this cycle
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse on tile completion

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; credit=D; delay line cleared; every output 0.
- FSM IDLE -> RUN on start_i: latch num_rows_i; clear rows_in, rows_out, rows_done.
- FSM RUN -> DONE when rows_done==num_rows (last sink beat seen).
- FSM DONE -> IDLE after exactly 1 cycle; done_o=1 only in DONE.
- start_i is ignored outside IDLE.
- IF write (combinational): src_ready_o = RUN & !if_full & (rows_in<num_rows). if_fifo_ctrl[0] = src_valid_i & src_ready_o. rows_in++ on each write.
- IF read (combinational): if_rd = RUN & !if_empty & (credit>0).
- pe_valid_o is registered: equals if_rd of the previous cycle (1-cycle FIFO read latency).
- Credit: decrements on if_rd, increments on OF read, unchanged when both occur in the same cycle; range 0..D. This guarantees an OF write never sees OF full.
- OF write: PE_LATENCY-deep shift register of pe_valid_o; its tail drives of_fifo_ctrl[0].
- OF write while of_full is a protocol error: the write is still issued. Credit must make this unreachable; assertion in sim.
- OF read: of_rd = RUN & !of_empty & sink_ready_i. sink_valid_o is the registered of_rd. rows_done++ on each sink_valid_o.
- Earliest latencies:
  - src accept at cycle t -> pe_valid_o at t+2.
  - OF write at t+2+PE_LATENCY.
  - sink_valid_o at t+4+PE_LATENCY.
- Simultaneous IF wr+rd and OF wr+rd are legal; both enables are asserted together.
- IF full: src_ready_o=0; source holds its row.
- IF/OF empty: the corresponding read is suppressed; no bubble accounting needed.
- rows_in saturates at num_rows; extra src_valid_i is never accepted.
- Reset mid-tile returns to IDLE immediately; the bank is reset by the same rst, so no drain is attempted.
- Counter widths are ROW_CNT_W; comparisons are unsigned.

Optional Feature:
FIFO_BANK_CTRL_PERF_EN
- Defined: adds outputs stall_src_o and stall_sink_o, each 16 bits.
  - stall_src_o counts RUN cycles with src_valid_i & !src_ready_o.
  - stall_sink_o counts RUN cycles with !of_empty & !sink_ready_i.
  - Both saturate at 0xFFFF, clear on start, and hold their value through DONE/IDLE.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_bank_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparams for ctrl/resp bit indices: WR=0, RD=1, FULL=0, EMPTY=1
  - PERF_CNT_W=16
- One sub-module, fifo_bank_credit: up/down credit counter with init D, plus dec/inc/has_credit.

Test Plan:
- num_rows=4, src_valid_i held 1, sink_ready_i=1, PE_LATENCY=3 -> first pe_valid_o 2 cycles after first accept, first sink_valid_o 7 cycles after it, 4 sink beats, done_o one cycle after the 4th beat.
- num_rows=8, sink_ready_i=0 -> after 4 IF reads credit=0 and no further if_rd; IF fills to 4 and src_ready_o drops; OF never receives a write while full. Raising sink_ready_i completes 8 rows.
- num_rows=0 -> behaves as 1; exactly one accept, one sink beat, done_o pulse.
- Steady state with sink_ready_i=1 -> if_fifo_ctrl=2'b11 and of_fifo_ctrl=2'b11 in the same cycle with credit unchanged; throughput is 1 row/cycle.
- rst low during RUN with rows_in=3 -> all outputs 0 asynchronously; a subsequent start with num_rows=2 completes normally.
- PERF_EN, src held valid, IF full for 5 cycles -> stall_src_o=5; a new start clears it to 0.
